// File: rtl/sata_pkg.sv
// Shared SATA PHY constants: primitive words, K28.3 marker byte and the OOB state encoding.
package sata_pkg;

    localparam logic [31:0] ALIGN_P    = 32'h7B4A4ABC;
    localparam logic [31:0] SYNC_P     = 32'hB5B5957C;
    localparam logic [31:0] D10_2_P    = 32'h4A4A4A4A;
    localparam logic [3:0]  ALIGN_K    = 4'b0001;
    localparam logic [7:0]  K28_3_MASK = 8'h7C;

    typedef enum logic [3:0] {
        S_RESET        = 4'd0,
        S_COMRESET     = 4'd1,
        S_WAIT_COMINIT = 4'd2,
        S_COMWAKE      = 4'd3,
        S_WAIT_COMWAKE = 4'd4,
        S_WAIT_ALIGN   = 4'd5,
        S_SEND_ALIGN   = 4'd6,
        S_READY        = 4'd7
    } oob_state_t;

endpackage

// File: rtl/sata_oobctrl.sv
// Host-side SATA OOB sequencer: COMRESET/COMWAKE handshake, ALIGN speed negotiation
// and hand-over of the transmitter to the link layer after three non-ALIGN primitives.
module sata_oobctrl
    import sata_pkg::*;
#(
    parameter logic [23:0] P_RESET_WAIT   = 24'd150000,
    parameter logic [23:0] P_COMWAKE_WAIT = 24'd150000,
    parameter logic [23:0] P_ALIGN_WAIT   = 24'd132000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_tx_comfinish,
    input  logic        i_rx_cominit_det,
    input  logic        i_rx_comwake_det,
    input  logic        i_rx_valid,
    input  logic [31:0] i_rx_data,
    input  logic [3:0]  i_rx_charisk,
    input  logic [31:0] i_link_data,
    input  logic [3:0]  i_link_charisk,
    output logic        o_tx_cominit,
    output logic        o_tx_comwake,
    output logic        o_tx_elecidle,
    output logic [31:0] o_tx_data,
    output logic [3:0]  o_tx_charisk,
    output logic        o_link_up,
    output logic [3:0]  o_state,
    output logic [7:0]  o_retries
);

    oob_state_t  state_reg, state_next;
    logic [23:0] timer_reg;
    logic [23:0] timer_limit;
    logic        timer_expired;
    logic        timeout;
    logic        entering;
    logic        comwake_seen_reg;
    logic [1:0]  sync_cnt_reg;
    logic        rx_align;
    logic        rx_prim;
    logic        cominit_reg;
    logic        comwake_reg;
    logic        elecidle_reg;
    logic [31:0] tx_data_reg;
    logic [3:0]  tx_charisk_reg;
    logic        link_up_reg;
    logic [7:0]  retries_reg;

    always_comb begin
        timer_limit = P_RESET_WAIT;
        case (state_reg)
            S_WAIT_COMWAKE:             timer_limit = P_COMWAKE_WAIT;
            S_WAIT_ALIGN, S_SEND_ALIGN: timer_limit = P_ALIGN_WAIT;
            default:                    timer_limit = P_RESET_WAIT;
        endcase
        timer_expired = (timer_reg == timer_limit - 24'd1);

        rx_align = i_rx_valid && (i_rx_charisk == ALIGN_K) && (i_rx_data == ALIGN_P);
        rx_prim  = i_rx_valid && i_rx_charisk[0] && (i_rx_data[7:0] == K28_3_MASK) && !rx_align;

        // A comfinish arriving while our own request pulse is still out is stale.
        state_next = state_reg;
        case (state_reg)
            S_RESET:        state_next = S_COMRESET;
            S_COMRESET:     if (i_tx_comfinish && !cominit_reg) state_next = S_WAIT_COMINIT;
            S_WAIT_COMINIT: if (i_rx_cominit_det) state_next = S_COMWAKE;
            S_COMWAKE:      if (i_tx_comfinish && !comwake_reg) state_next = S_WAIT_COMWAKE;
            S_WAIT_COMWAKE: if (comwake_seen_reg && !i_rx_comwake_det) state_next = S_WAIT_ALIGN;
            S_WAIT_ALIGN:   if (rx_align) state_next = S_SEND_ALIGN;
            S_SEND_ALIGN:   if (rx_prim && sync_cnt_reg == 2'd2) state_next = S_READY;
            S_READY:        if (i_rx_cominit_det) state_next = S_COMWAKE;
            default:        state_next = S_RESET;
        endcase

        // Timeout only applies when no event moved us this cycle.
        timeout = (state_reg != S_RESET) && (state_reg != S_READY)
                  && (state_next == state_reg) && timer_expired;
        if (timeout)
            state_next = S_COMRESET;

        entering = (state_next != state_reg) || timeout;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_reg        <= S_RESET;
            timer_reg        <= '0;
            comwake_seen_reg <= 1'b0;
            sync_cnt_reg     <= '0;
            cominit_reg      <= 1'b0;
            comwake_reg      <= 1'b0;
            elecidle_reg     <= 1'b1;
            tx_data_reg      <= '0;
            tx_charisk_reg   <= '0;
            link_up_reg      <= 1'b0;
            retries_reg      <= '0;
        end else begin
            state_reg <= state_next;
            timer_reg <= (entering || state_next == S_READY) ? 24'd0 : timer_reg + 24'd1;

            if (entering)
                comwake_seen_reg <= 1'b0;
            else if (state_reg == S_WAIT_COMWAKE && i_rx_comwake_det)
                comwake_seen_reg <= 1'b1;

            if (entering)
                sync_cnt_reg <= '0;
            else if (state_reg == S_SEND_ALIGN && i_rx_valid)
                sync_cnt_reg <= rx_prim ? sync_cnt_reg + 2'd1 : 2'd0;

            cominit_reg  <= (state_next == S_COMRESET) && entering;
            comwake_reg  <= (state_next == S_COMWAKE) && entering;
            elecidle_reg <= !(state_next inside {S_WAIT_ALIGN, S_SEND_ALIGN, S_READY});
            link_up_reg  <= (state_next == S_READY);

            case (state_next)
                S_WAIT_ALIGN: begin
                    tx_data_reg    <= D10_2_P;
                    tx_charisk_reg <= 4'b0000;
                end
                S_SEND_ALIGN: begin
                    tx_data_reg    <= ALIGN_P;
                    tx_charisk_reg <= ALIGN_K;
                end
                S_READY: begin
                    tx_data_reg    <= i_link_data;
                    tx_charisk_reg <= i_link_charisk;
                end
                default: begin
                    tx_data_reg    <= '0;
                    tx_charisk_reg <= '0;
                end
            endcase

            if (timeout && retries_reg != 8'hFF)
                retries_reg <= retries_reg + 8'd1;
        end
    end

    assign o_tx_cominit  = cominit_reg;
    assign o_tx_comwake  = comwake_reg;
    assign o_tx_elecidle = elecidle_reg;
    assign o_tx_data     = tx_data_reg;
    assign o_tx_charisk  = tx_charisk_reg;
    assign o_link_up     = link_up_reg;
    assign o_state       = state_reg;
    assign o_retries     = retries_reg;

endmodule

// File: tb/tb_sata_oobctrl.sv
// Bench for sata_oobctrl: table of held-input segments with expected outputs after each,
// queued as expectations and checked after the closing clock edge.
module tb_sata_oobctrl;

    localparam logic [31:0] ALN = 32'h7B4A4ABC;
    localparam logic [31:0] SYN = 32'hB5B5957C;
    localparam logic [31:0] D10 = 32'h4A4A4A4A;
    localparam logic [31:0] LNK = 32'h12345678;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tx_comfinish = 1'b0;
    logic        rx_cominit_det = 1'b0;
    logic        rx_comwake_det = 1'b0;
    logic        rx_valid = 1'b0;
    logic [31:0] rx_data = '0;
    logic [3:0]  rx_charisk = '0;
    logic [31:0] link_data = '0;
    logic [3:0]  link_charisk = '0;
    logic        tx_cominit, tx_comwake, tx_elecidle, link_up;
    logic [31:0] tx_data;
    logic [3:0]  tx_charisk, state;
    logic [7:0]  retries;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sata_oobctrl #(
        .P_RESET_WAIT  (24'd100),
        .P_COMWAKE_WAIT(24'd100),
        .P_ALIGN_WAIT  (24'd100)
    ) dut (
        .i_clk           (clk),
        .i_reset_n       (reset_n),
        .i_tx_comfinish  (tx_comfinish),
        .i_rx_cominit_det(rx_cominit_det),
        .i_rx_comwake_det(rx_comwake_det),
        .i_rx_valid      (rx_valid),
        .i_rx_data       (rx_data),
        .i_rx_charisk    (rx_charisk),
        .i_link_data     (link_data),
        .i_link_charisk  (link_charisk),
        .o_tx_cominit    (tx_cominit),
        .o_tx_comwake    (tx_comwake),
        .o_tx_elecidle   (tx_elecidle),
        .o_tx_data       (tx_data),
        .o_tx_charisk    (tx_charisk),
        .o_link_up       (link_up),
        .o_state         (state),
        .o_retries       (retries)
    );

    // n: cycles the inputs are held; expectations apply after the last of those edges.
    typedef struct {
        int          n;
        logic        rst, fin, cid, cwd, val;
        logic [31:0] rxd;
        logic [3:0]  rxk;
        logic [31:0] lnd;
        logic [3:0]  lnk;
        logic [3:0]  s;
        logic        lu, ei, tci, tcw;
        logic [7:0]  rt;
        logic [31:0] txd;
        logic [3:0]  txk;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        vec_t v, e;
        int   cnt;
        //            n   rst fin cid cwd val rxd  rxk lnd  lnk  s  lu ei tci tcw rt   txd  txk
        vecs.push_back(vec_t'{2,     0,0,0,0,0, 0,   0, 0,   0,   0, 0,1,0,0, 0,   0,   0});
        vecs.push_back(vec_t'{1,     1,0,0,0,0, 0,   0, 0,   0,   1, 0,1,1,0, 0,   0,   0});
        vecs.push_back(vec_t'{1,     1,1,0,0,0, 0,   0, 0,   0,   1, 0,1,0,0, 0,   0,   0});
        vecs.push_back(vec_t'{1,     1,1,0,0,0, 0,   0, 0,   0,   2, 0,1,0,0, 0,   0,   0});
        vecs.push_back(vec_t'{5,     1,0,0,0,0, 0,   0, 0,   0,   2, 0,1,0,0, 0,   0,   0});
        vecs.push_back(vec_t'{1,     1,0,1,0,0, 0,   0, 0,   0,   3, 0,1,0,1, 0,   0,   0});
        vecs.push_back(vec_t'{1,     1,1,0,0,0, 0,   0, 0,   0,   3, 0,1,0,0, 0,   0,   0});
        vecs.push_back(vec_t'{1,     1,1,0,0,0, 0,   0, 0,   0,   4, 0,1,0,0, 0,   0,   0});
        vecs.push_back(vec_t'{20,    1,0,0,1,0, 0,   0, 0,   0,   4, 0,1,0,0, 0,   0,   0});
        vecs.push_back(vec_t'{1,     1,0,0,0,0, 0,   0, 0,   0,   5, 0,0,0,0, 0,   D10, 0});
        vecs.push_back(vec_t'{1,     1,0,0,0,1, ALN, 1, 0,   0,   6, 0,0,0,0, 0,   ALN, 1});
        vecs.push_back(vec_t'{1,     1,0,0,0,1, ALN, 1, 0,   0,   6, 0,0,0,0, 0,   ALN, 1});
        vecs.push_back(vec_t'{2,     1,0,0,0,1, SYN, 1, 0,   0,   6, 0,0,0,0, 0,   ALN, 1});
        vecs.push_back(vec_t'{1,     1,0,0,0,1, SYN, 1, 0,   0,   7, 1,0,0,0, 0,   0,   0});
        vecs.push_back(vec_t'{1,     1,0,0,0,0, 0,   0, LNK, 3,   7, 1,0,0,0, 0,   LNK, 3});
        vecs.push_back(vec_t'{1,     1,0,1,0,0, 0,   0, 0,   0,   3, 0,1,0,1, 0,   0,   0});
        vecs.push_back(vec_t'{1,     1,1,0,0,0, 0,   0, 0,   0,   3, 0,1,0,0, 0,   0,   0});
        vecs.push_back(vec_t'{1,     1,1,0,0,0, 0,   0, 0,   0,   4, 0,1,0,0, 0,   0,   0});
        vecs.push_back(vec_t'{3,     1,0,0,1,0, 0,   0, 0,   0,   4, 0,1,0,0, 0,   0,   0});
        vecs.push_back(vec_t'{1,     1,0,0,0,0, 0,   0, 0,   0,   5, 0,0,0,0, 0,   D10, 0});
        vecs.push_back(vec_t'{1,     1,0,0,0,1, ALN, 1, 0,   0,   6, 0,0,0,0, 0,   ALN, 1});
        vecs.push_back(vec_t'{2,     1,0,0,0,1, SYN, 1, 0,   0,   6, 0,0,0,0, 0,   ALN, 1});
        vecs.push_back(vec_t'{1,     1,0,0,0,1, ALN, 1, 0,   0,   6, 0,0,0,0, 0,   ALN, 1});
        vecs.push_back(vec_t'{2,     1,0,0,0,1, SYN, 1, 0,   0,   6, 0,0,0,0, 0,   ALN, 1});
        vecs.push_back(vec_t'{1,     1,0,0,0,1, ALN, 1, 0,   0,   6, 0,0,0,0, 0,   ALN, 1});
        vecs.push_back(vec_t'{1,     1,0,0,0,1, SYN, 1, 0,   0,   6, 0,0,0,0, 0,   ALN, 1});
        vecs.push_back(vec_t'{2,     1,0,0,0,0, SYN, 1, 0,   0,   6, 0,0,0,0, 0,   ALN, 1});
        vecs.push_back(vec_t'{1,     1,0,0,0,1, SYN, 1, 0,   0,   6, 0,0,0,0, 0,   ALN, 1});
        vecs.push_back(vec_t'{1,     1,0,0,0,0, SYN, 1, 0,   0,   6, 0,0,0,0, 0,   ALN, 1});
        vecs.push_back(vec_t'{1,     1,0,0,0,1, SYN, 1, 0,   0,   7, 1,0,0,0, 0,   0,   0});
        vecs.push_back(vec_t'{1,     1,0,1,0,0, 0,   0, 0,   0,   3, 0,1,0,1, 0,   0,   0});
        vecs.push_back(vec_t'{1,     1,1,0,0,0, 0,   0, 0,   0,   3, 0,1,0,0, 0,   0,   0});
        vecs.push_back(vec_t'{1,     1,1,0,0,0, 0,   0, 0,   0,   4, 0,1,0,0, 0,   0,   0});
        vecs.push_back(vec_t'{2,     1,0,0,1,0, 0,   0, 0,   0,   4, 0,1,0,0, 0,   0,   0});
        vecs.push_back(vec_t'{1,     1,0,0,0,0, 0,   0, 0,   0,   5, 0,0,0,0, 0,   D10, 0});
        vecs.push_back(vec_t'{99,    1,0,0,0,1, D10, 0, 0,   0,   5, 0,0,0,0, 0,   D10, 0});
        vecs.push_back(vec_t'{1,     1,0,0,0,1, D10, 0, 0,   0,   1, 0,1,1,0, 1,   0,   0});
        vecs.push_back(vec_t'{99,    1,0,0,0,0, 0,   0, 0,   0,   1, 0,1,0,0, 1,   0,   0});
        vecs.push_back(vec_t'{1,     1,0,0,0,0, 0,   0, 0,   0,   1, 0,1,1,0, 2,   0,   0});
        vecs.push_back(vec_t'{100,   1,0,0,0,0, 0,   0, 0,   0,   1, 0,1,1,0, 3,   0,   0});
        vecs.push_back(vec_t'{25200, 1,0,0,0,0, 0,   0, 0,   0,   1, 0,1,1,0, 255, 0,   0});
        vecs.push_back(vec_t'{100,   1,0,0,0,0, 0,   0, 0,   0,   1, 0,1,1,0, 255, 0,   0});
        vecs.push_back(vec_t'{1,     1,1,0,0,0, 0,   0, 0,   0,   1, 0,1,0,0, 255, 0,   0});
        vecs.push_back(vec_t'{1,     1,1,0,0,0, 0,   0, 0,   0,   2, 0,1,0,0, 255, 0,   0});
        vecs.push_back(vec_t'{1,     1,0,1,0,0, 0,   0, 0,   0,   3, 0,1,0,1, 255, 0,   0});
        vecs.push_back(vec_t'{1,     1,1,0,0,0, 0,   0, 0,   0,   3, 0,1,0,0, 255, 0,   0});
        vecs.push_back(vec_t'{1,     1,1,0,0,0, 0,   0, 0,   0,   4, 0,1,0,0, 255, 0,   0});
        vecs.push_back(vec_t'{1,     1,0,0,1,0, 0,   0, 0,   0,   4, 0,1,0,0, 255, 0,   0});
        vecs.push_back(vec_t'{1,     1,0,0,0,0, 0,   0, 0,   0,   5, 0,0,0,0, 255, D10, 0});
        vecs.push_back(vec_t'{1,     0,0,0,0,0, 0,   0, 0,   0,   0, 0,1,0,0, 0,   0,   0});
        vecs.push_back(vec_t'{1,     1,0,0,0,0, 0,   0, 0,   0,   1, 0,1,1,0, 0,   0,   0});

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            reset_n        = v.rst;
            tx_comfinish   = v.fin;
            rx_cominit_det = v.cid;
            rx_comwake_det = v.cwd;
            rx_valid       = v.val;
            rx_data        = v.rxd;
            rx_charisk     = v.rxk;
            link_data      = v.lnd;
            link_charisk   = v.lnk;
            repeat (v.n - 1) @(posedge clk);
            exp_q.push_back(v);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check("state",    i, 32'(state),       32'(e.s));
            check("link_up",  i, 32'(link_up),     32'(e.lu));
            check("elecidle", i, 32'(tx_elecidle), 32'(e.ei));
            check("cominit",  i, 32'(tx_cominit),  32'(e.tci));
            check("comwake",  i, 32'(tx_comwake),  32'(e.tcw));
            check("retries",  i, 32'(retries),     32'(e.rt));
            check("tx_data",  i, tx_data,          e.txd);
            check("tx_k",     i, 32'(tx_charisk),  32'(e.txk));
            $display("vec %0d: n=%0d state=%0d link_up=%0b elecidle=%0b cominit=%0b comwake=%0b retries=%0d tx=%h/%h",
                     i, v.n, state, link_up, tx_elecidle, tx_cominit, tx_comwake, retries, tx_data, tx_charisk);
        end

        // COMRESET pulse is one cycle wide and repeats every 100 cycles while no COMINIT arrives.
        @(posedge clk);
        #1;
        check("cominit_width", 0, 32'(tx_cominit), 32'd0);
        cnt = 1;
        while (!tx_cominit && cnt < 200) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("cominit_period", 0, 32'(cnt), 32'd100);
        check("retries_after_reset", 0, 32'(retries), 32'd1);
        $display("cominit period: %0d cycles, retries=%0d", cnt, retries);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
